// File: rtl/ddr_nibble_tx.sv
// ddr_nibble_tx: buffers (hi, lo) nibble pairs and serializes them,
// high-phase nibble then low-phase nibble, on one registered nibble bus.
//
// Ports:
//   clk, rst            fabric clock, synchronous active-high reset
//   in_hi, in_lo        nibble pair from the producer
//   in_valid, in_ready  producer handshake
//   out_data            serialized nibble, IDLE_PAT when idle
//   out_phase           1 = high-phase slot, 0 = low-phase slot or idle
//   out_valid           out_data carries a real nibble
//   out_par             even parity of out_data, 0 when idle
//                       (present only when DDR_TX_PARITY_EN is defined)
//   level               FIFO occupancy in pairs
//
// Optional feature macro: DDR_TX_PARITY_EN
module ddr_nibble_tx #(
  parameter int            W        = 4,
  parameter int            DEPTH    = 2,
  parameter logic [W-1:0]  IDLE_PAT = '0,
  localparam int           LW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_hi,
  input  logic [W-1:0]  in_lo,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_data,
  output logic          out_phase,
  output logic          out_valid,
`ifdef DDR_TX_PARITY_EN
  output logic          out_par,
`endif
  output logic [LW-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  state_t state, state_n;

  logic [2*W-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [2*W-1:0] head;
  logic [2*W-1:0] hold, hold_n;

  logic           push;
  logic           pop;
  logic           full;
  logic           empty;

  logic [W-1:0]   data_n;
  logic           phase_n;
  logic           valid_n;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  // The output registers are loaded with the content of the slot the
  // FSM is entering, so each state's nibble appears right after the
  // edge that enters it.
  always_comb begin
    state_n = state;
    hold_n  = hold;
    pop     = 1'b0;
    data_n  = IDLE_PAT;
    phase_n = 1'b0;
    valid_n = 1'b0;
    unique case (state)
      IDLE, LO: begin
        if (!empty) begin
          pop     = 1'b1;
          hold_n  = head;
          state_n = HI;
          data_n  = head[2*W-1:W];
          phase_n = 1'b1;
          valid_n = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      HI: begin
        state_n = LO;
        data_n  = hold[W-1:0];
        valid_n = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Storage array needs no reset: occupancy is tracked by level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_hi, in_lo};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      hold      <= '0;
      out_data  <= IDLE_PAT;
      out_phase <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      out_data  <= data_n;
      out_phase <= phase_n;
      out_valid <= valid_n;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef DDR_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_par <= 1'b0;
    end else begin
      out_par <= valid_n && (^data_n);
    end
  end
`endif

endmodule

// File: doc/ddr_nibble_tx.md
Name: ddr_nibble_tx

Overview:
- Transmit end of the dual-phase nibble link. The capture side latches one nibble in the high clock phase and a second nibble in the low phase.
- This block accepts (hi, lo) nibble pairs over a valid/ready handshake and buffers them in a small FIFO.
- It serializes each pair onto a single nibble bus at the 2x fabric clock. out_phase marks which slot each nibble belongs to.
- Sits between the word-level producer and the link pad/capture logic.

Parameters:
- W, 4, nibble width in bits.
- DEPTH, 2, FIFO depth in nibble pairs. Power of 2, >= 2.
- IDLE_PAT, 0, value driven on out_data when no nibble is being sent.

Ports:
- clk  input  1  fabric clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_hi  input  W  nibble for the high-phase slot.
- in_lo  input  W  nibble for the low-phase slot.
- in_valid  input  1  producer offers a pair.
- in_ready  output  1  block can accept a pair.
- out_data  output  W  serialized nibble (registered).
- out_phase  output  1  1 = high-phase slot, 0 = low-phase slot or idle (registered).
- out_valid  output  1  out_data carries a real nibble (registered).
- level  output  $clog2(DEPTH+1)  FIFO occupancy in pairs (registered).

Behaviour:
- Clock and reset: one clock, clk, rising edge. Reset rst is synchronous and active-high.
- Reset values (rst sampled high):
  - out_data=IDLE_PAT, out_phase=0, out_valid=0, level=0.
  - FIFO pointers=0, FSM=IDLE.
  - in_ready=0 while rst is high.
- Handshake:
  - in_ready = !rst && (level != DEPTH), combinational from registered state.
  - A push occurs on a clk edge with in_valid && in_ready. {in_hi, in_lo} is written at wr_ptr.
  - No pass-through: a push into a full FIFO is impossible, even if a pop happens in the same cycle.
  - Producer must hold in_hi, in_lo and in_valid stable until accepted.
- FIFO:
  - Pointers wrap modulo DEPTH.
  - level increments on push only, decrements on pop only, and is unchanged on simultaneous push+pop.
- FSM states: IDLE, HI, LO.
  - IDLE:
    - out_valid=0, out_phase=0, out_data=IDLE_PAT.
    - If level!=0: pop head into the hold register; next state is HI.
  - HI:
    - out_data=hold.hi, out_phase=1, out_valid=1.
    - Next state is LO unconditionally.
  - LO:
    - out_data=hold.lo, out_phase=0, out_valid=1.
    - If level!=0: pop and go to HI. Back-to-back pairs run with no idle bubble.
    - Otherwise go to IDLE.
- Latency: pair pushed at edge k into an empty FIFO in IDLE:
  - popped at edge k+1;
  - hi nibble visible after edge k+1;
  - lo nibble visible after edge k+2.
- Throughput: max one pair per 2 clocks. Sustained input faster than that fills the FIFO and deasserts in_ready.
- Ordering: strict FIFO. Within a pair, hi is always sent before lo.
- Reset mid-operation: the pair in flight is dropped, the FIFO is flushed, and outputs return to reset values on the same edge.
- Push during rst: ignored.
- Every emitted HI slot is followed by its LO slot on the very next clock. No partial pairs are sent except when truncated by reset.

Optional Feature:
- Macro: DDR_TX_PARITY_EN.
- When defined:
  - Adds output out_par (1 bit, registered).
  - out_par = ^out_data (even parity over the nibble) whenever out_valid=1, and 0 when idle or in reset.
  - The FIFO width is unchanged; parity is computed from the hold register at slot load.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=1 for 3 clocks with in_valid=1.
  -> out_valid=0, out_data=0, out_phase=0, level=0, in_ready=0.
  -> Nothing is transmitted after release.
- Single pair: push hi=3, lo=4 at edge k.
  -> After k+1: data=3, phase=1, valid=1.
  -> After k+2: data=4, phase=0, valid=1.
  -> After k+3: valid=0, data=0.
- Back-to-back pairs: push (5,8) then (12,13) on consecutive edges.
  -> Output sequence 5/1, 8/0, 12/1, 13/0 on consecutive clocks, with no bubble.
  -> level peaks at 1.
- FIFO full: push (1,2), (3,4), (5,6), (7,8) with in_valid held continuously.
  -> in_ready drops when level=2.
  -> All 8 nibbles emerge in order 1..8.
  -> No pair is lost or duplicated; level returns to 0.
- Reset mid-word: push (9,10); assert rst for one clock on the edge where hi=9 is showing.
  -> The next cycle shows valid=0, data=0.
  -> 10 is never emitted; level=0.
- Parity (DDR_TX_PARITY_EN): send (7,3) -> out_par=1 with 7, out_par=0 with 3, out_par=0 when idle.
